// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: decodes RV32I loads/stores, runs a req/ack data-bus access,
// aligns/extends load data and stalls the pipe while the access is open.
module mem_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_100MHz,
  input  logic        arst_n,
  input  logic [31:0] inst_i,
  input  logic        reg_w_ena_i,
  input  logic [4:0]  reg_w_addr_i,
  input  logic [31:0] reg_w_data_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_w_data_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_be_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_ack_i,
  input  logic [31:0] dbus_rdata_i,
  output logic        hold_req_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic [31:0] inst_o,
  output logic        mem_r_ena_o,
  output logic [31:0] mem_r_data_o,
  output logic [31:0] mem_r_addr_o,
  output logic        reg_w_ena_o,
  output logic [4:0]  reg_w_addr_o,
  output logic [31:0] reg_w_data_o,
  output logic        mem_w_ena_o,
  output logic [31:0] mem_w_addr_o,
  output logic [31:0] mem_w_data_o
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [31:0] data_q;
  logic        err_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [1:0]  lane;
  logic        is_load, is_store, is_mem, misaligned;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_shift, ld_data;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign lane   = mem_addr_i[1:0];

  always_comb begin
    is_load  = (opcode == 7'b0000011) &&
               (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    is_store = (opcode == 7'b0100011) && (funct3 inside {3'b000, 3'b001, 3'b010});
    is_mem   = is_load || is_store;
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b01:   misaligned = lane[0];
      2'b10:   misaligned = (lane != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  // Store lane steering; loads always read the whole word.
  always_comb begin
    st_be    = 4'hF;
    st_wdata = mem_w_data_i;
    case (funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << lane;
        st_wdata = {4{mem_w_data_i[7:0]}};
      end
      2'b01: begin
        st_be    = lane[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{mem_w_data_i[15:0]}};
      end
      default: begin
        st_be    = 4'hF;
        st_wdata = mem_w_data_i;
      end
    endcase
  end

  always_comb begin
    ld_shift = data_q >> {lane, 3'b000};
    case (funct3)
      3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_data = {24'h0, ld_shift[7:0]};
      3'b101:  ld_data = {16'h0, ld_shift[15:0]};
      default: ld_data = data_q;
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_q <= 8'd0;
          err_q <= 1'b0;
          if (is_mem && !misaligned) state_q <= StAccess;
        end
        StAccess: begin
          if (dbus_ack_i) begin
            data_q  <= dbus_rdata_i;
            cnt_q   <= 8'd0;
            state_q <= StDone;
          end else if (cnt_q == 8'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            cnt_q   <= 8'd0;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StDone: begin
          err_q   <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs are forced low while reset is asserted, including the pass-through path.
  always_comb begin
    dbus_req_o   = 1'b0;
    dbus_we_o    = 1'b0;
    dbus_addr_o  = 32'h0;
    dbus_be_o    = 4'h0;
    dbus_wdata_o = 32'h0;
    hold_req_o   = 1'b0;
    misalign_o   = 1'b0;
    bus_err_o    = 1'b0;
    inst_o       = 32'h0;
    mem_r_ena_o  = 1'b0;
    mem_r_data_o = 32'h0;
    mem_r_addr_o = 32'h0;
    reg_w_ena_o  = 1'b0;
    reg_w_addr_o = 5'h0;
    reg_w_data_o = 32'h0;
    mem_w_ena_o  = 1'b0;
    mem_w_addr_o = 32'h0;
    mem_w_data_o = 32'h0;
    if (arst_n) begin
      inst_o       = inst_i;
      reg_w_ena_o  = reg_w_ena_i;
      reg_w_addr_o = reg_w_addr_i;
      reg_w_data_o = reg_w_data_i;
      if ((state_q == StAccess) || ((state_q == StIdle) && is_mem && !misaligned)) begin
        dbus_req_o   = 1'b1;
        hold_req_o   = 1'b1;
        reg_w_ena_o  = 1'b0;
        dbus_we_o    = is_store;
        dbus_addr_o  = {mem_addr_i[31:2], 2'b00};
        dbus_be_o    = is_store ? st_be : 4'hF;
        dbus_wdata_o = is_store ? st_wdata : 32'h0;
      end else if ((state_q == StIdle) && is_mem) begin
        misalign_o  = 1'b1;
        reg_w_ena_o = 1'b0;
      end else if (state_q == StDone) begin
        if (err_q) begin
          bus_err_o   = 1'b1;
          reg_w_ena_o = 1'b0;
        end else if (is_load) begin
          mem_r_ena_o  = 1'b1;
          mem_r_data_o = ld_data;
          mem_r_addr_o = mem_addr_i;
          reg_w_data_o = ld_data;
        end else if (is_store) begin
          mem_w_ena_o  = 1'b1;
          mem_w_addr_o = mem_addr_i;
          mem_w_data_o = mem_w_data_i;
          reg_w_ena_o  = 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed and randomized checks of mem_lsu against an arithmetic reference model.
module tb_mem_lsu;

  localparam int unsigned Timeout = 4;
  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk_100MHz = 1'b0;
  logic        arst_n;
  logic [31:0] inst_i;
  logic        reg_w_ena_i;
  logic [4:0]  reg_w_addr_i;
  logic [31:0] reg_w_data_i, mem_addr_i, mem_w_data_i;
  logic        dbus_req_o, dbus_we_o, dbus_ack_i;
  logic [31:0] dbus_addr_o, dbus_wdata_o, dbus_rdata_i;
  logic [3:0]  dbus_be_o;
  logic        hold_req_o, misalign_o, bus_err_o;
  logic [31:0] inst_o, mem_r_data_o, mem_r_addr_o, reg_w_data_o, mem_w_addr_o, mem_w_data_o;
  logic        mem_r_ena_o, reg_w_ena_o, mem_w_ena_o;
  logic [4:0]  reg_w_addr_o;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk_100MHz = ~clk_100MHz;

  mem_lsu #(.TIMEOUT(Timeout)) dut (
    .clk_100MHz(clk_100MHz), .arst_n(arst_n), .inst_i(inst_i), .reg_w_ena_i(reg_w_ena_i),
    .reg_w_addr_i(reg_w_addr_i), .reg_w_data_i(reg_w_data_i), .mem_addr_i(mem_addr_i),
    .mem_w_data_i(mem_w_data_i), .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o),
    .dbus_addr_o(dbus_addr_o), .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_ack_i(dbus_ack_i), .dbus_rdata_i(dbus_rdata_i), .hold_req_o(hold_req_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o), .inst_o(inst_o),
    .mem_r_ena_o(mem_r_ena_o), .mem_r_data_o(mem_r_data_o), .mem_r_addr_o(mem_r_addr_o),
    .reg_w_ena_o(reg_w_ena_o), .reg_w_addr_o(reg_w_addr_o), .reg_w_data_o(reg_w_data_o),
    .mem_w_ena_o(mem_w_ena_o), .mem_w_addr_o(mem_w_addr_o), .mem_w_data_o(mem_w_data_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic is_ld, input logic [2:0] f3);
    logic [31:0] r;
    r = $urandom;
    r[6:0] = is_ld ? 7'h03 : 7'h23;
    r[14:12] = f3;
    return r;
  endfunction

  // Reference: access size in bytes is 1 << f3[1:0]; a misaligned address is not a multiple.
  function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] addr);
    int sz;
    sz = 1 << f3[1:0];
    return (addr % sz) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] word,
                                           input logic [31:0] addr);
    longint v;
    v = longint'(word) >> (8 * (addr % 4));
    case (f3)
      3'b000: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
      3'b001: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
      3'b100: v = v % 256;
      3'b101: v = v % 65536;
      default: v = word;
    endcase
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] addr);
    case (f3)
      3'b000:  return 4'(1 << (addr % 4));
      3'b001:  return 4'(3 << (addr % 4));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return (d % 256) * 32'h0101_0101;
      3'b001:  return (d % 65536) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  task automatic set_nop();
    inst_i = Nop; reg_w_ena_i = 1'b0; reg_w_addr_i = 5'd0; reg_w_data_i = 32'h0;
    mem_addr_i = 32'h0; mem_w_data_i = 32'h0; dbus_ack_i = 1'b0; dbus_rdata_i = 32'h0;
  endtask

  // ack_at: ACCESS cycle (1-based) in which ack is driven; 0 means never (timeout).
  task automatic run_mem(input logic is_ld, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int ack_at, input logic [31:0] rd);
    int holds;
    @(posedge clk_100MHz); #1;
    inst_i = mk_inst(is_ld, f3); reg_w_ena_i = is_ld; reg_w_addr_i = 5'($urandom);
    reg_w_data_i = $urandom; mem_addr_i = addr; mem_w_data_i = wd;
    dbus_ack_i = 1'b1; dbus_rdata_i = ~rd;  // ack in the issue cycle must be ignored
    #1;
    chk("issue_req", dbus_req_o, 1);
    chk("issue_hold", hold_req_o, 1);
    chk("issue_we", dbus_we_o, !is_ld);
    chk("issue_addr", dbus_addr_o, {addr[31:2], 2'b00});
    chk("issue_be", dbus_be_o, is_ld ? 4'hF : ref_be(f3, addr));
    if (!is_ld) chk("issue_wdata", dbus_wdata_o, ref_wdata(f3, wd));
    chk("issue_rwe", reg_w_ena_o, 0);
    holds = 1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk_100MHz); #1;
      dbus_ack_i = (k == ack_at);
      dbus_rdata_i = (k == ack_at) ? rd : $urandom;
      #1;
      if (!hold_req_o) break;
      holds++;
    end
    chk("hold_cycles", holds, (ack_at == 0) ? 1 + Timeout : 1 + ack_at);
    chk("done_req", dbus_req_o, 0);
    chk("done_buserr", bus_err_o, ack_at == 0);
    if (ack_at == 0) begin
      chk("err_rwe", reg_w_ena_o, 0);
      chk("err_mem_ena", {mem_r_ena_o, mem_w_ena_o}, 0);
    end else if (is_ld) begin
      chk("ld_r_ena", mem_r_ena_o, 1);
      chk("ld_data", reg_w_data_o, ref_load(f3, rd, addr));
      chk("ld_r_data", mem_r_data_o, ref_load(f3, rd, addr));
      chk("ld_r_addr", mem_r_addr_o, addr);
      chk("ld_rwe", reg_w_ena_o, 1);
    end else begin
      chk("st_w_ena", mem_w_ena_o, 1);
      chk("st_w_addr", mem_w_addr_o, addr);
      chk("st_w_data", mem_w_data_o, wd);
      chk("st_rwe", reg_w_ena_o, 0);
    end
    @(posedge clk_100MHz); #1;
    set_nop();
    #1;
    chk("back_idle_hold", hold_req_o, 0);
    chk("back_idle_err", bus_err_o, 0);
  endtask

  task automatic run_misalign(input logic is_ld, input logic [2:0] f3, input logic [31:0] addr);
    @(posedge clk_100MHz); #1;
    inst_i = mk_inst(is_ld, f3); reg_w_ena_i = 1'b1; mem_addr_i = addr;
    mem_w_data_i = $urandom; dbus_ack_i = 1'b0;
    #1;
    chk("mis_pulse", misalign_o, 1);
    chk("mis_req", dbus_req_o, 0);
    chk("mis_hold", hold_req_o, 0);
    chk("mis_rwe", reg_w_ena_o, 0);
    chk("mis_mem_ena", {mem_r_ena_o, mem_w_ena_o}, 0);
    @(posedge clk_100MHz); #1;
    set_nop();
    #1;
    chk("mis_stay_idle", {dbus_req_o, hold_req_o, misalign_o}, 0);
  endtask

  initial begin
    logic [2:0] f3;
    logic       is_ld;
    logic [31:0] addr;
    int ack_at;

    arst_n = 1'b0;
    set_nop();
    inst_i = 32'h0071_02B3; reg_w_ena_i = 1'b1; reg_w_data_i = 32'h1234_5678;
    #2;
    chk("rst_inst", inst_o, 0);
    chk("rst_rwe", reg_w_ena_o, 0);
    chk("rst_rdata", reg_w_data_o, 0);
    chk("rst_req_hold", {dbus_req_o, hold_req_o}, 0);
    @(posedge clk_100MHz); #1;
    arst_n = 1'b1;

    // ADD x5 pass-through
    inst_i = 32'h0020_82B3; reg_w_ena_i = 1'b1; reg_w_addr_i = 5'd5; reg_w_data_i = 32'd7;
    #1;
    chk("add_inst", inst_o, 32'h0020_82B3);
    chk("add_data", reg_w_data_o, 7);
    chk("add_en_addr", {reg_w_ena_o, reg_w_addr_o}, {1'b1, 5'd5});
    chk("add_quiet", {dbus_req_o, hold_req_o, mem_r_ena_o, mem_w_ena_o, misalign_o}, 0);

    // Undefined funct3 on load opcode passes through
    inst_i = mk_inst(1'b1, 3'b011); mem_addr_i = 32'h100;
    #1;
    chk("undef_req", {dbus_req_o, hold_req_o, misalign_o}, 0);
    chk("undef_rwe", reg_w_ena_o, 1);

    run_mem(1'b1, 3'b010, 32'h100, 32'h0, 3, 32'hDEAD_BEEF);
    run_mem(1'b1, 3'b000, 32'h103, 32'h0, 1, 32'h8011_2233);
    run_mem(1'b1, 3'b100, 32'h103, 32'h0, 2, 32'h8011_2233);
    run_mem(1'b1, 3'b101, 32'h102, 32'h0, 1, 32'h8011_2233);
    run_mem(1'b0, 3'b001, 32'h102, 32'h0000_ABCD, 2, 32'h0);
    run_misalign(1'b1, 3'b010, 32'h101);
    run_mem(1'b1, 3'b010, 32'h200, 32'h0, 0, 32'h0);

    // Reset during ACCESS
    @(posedge clk_100MHz); #1;
    inst_i = mk_inst(1'b1, 3'b010); mem_addr_i = 32'h300; reg_w_ena_i = 1'b1;
    @(posedge clk_100MHz); #1;
    @(posedge clk_100MHz); #1;
    arst_n = 1'b0;
    #1;
    chk("midrst_req", dbus_req_o, 0);
    chk("midrst_hold", hold_req_o, 0);
    set_nop();
    @(posedge clk_100MHz); #1;
    arst_n = 1'b1;
    run_mem(1'b1, 3'b010, 32'h300, 32'h0, 2, 32'hCAFE_F00D);

    for (int i = 0; i < 30; i++) begin
      is_ld = 1'($urandom);
      f3 = 3'($urandom_range(0, 2));
      if (is_ld && $urandom_range(0, 1) == 1 && f3 != 3'b010) f3[2] = 1'b1;
      addr = $urandom;
      ack_at = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 3));
      if (ref_misaligned(f3, addr)) run_misalign(is_ld, f3, addr);
      else run_mem(is_ld, f3, addr, $urandom, ack_at, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
